// File: rtl/maze_memory.sv
// ----------------------------------------------------------------------------
// maze_memory
//
// Maze storage for the wall-follower solver. It holds an N x N wall bitmap
// and a matching visited bitmap, where N = 2**maze_width.
//
// Operation cycles through three phases:
//   LOAD  : the host writes wall rows, one beat per row.
//   SERVE : the solver reads wall bits and marks cells as visited.
//   DUMP  : the visited map is streamed back to the host, one row per beat.
//
// Ports
//   clk, rst_n                       clock, asynchronous active-low reset
//   load_valid/ready/row/data/last   host wall-row load channel
//   row, col, maze_oe, maze_we       solver cell select and read/write strobes
//   done                             solver exit-found flag (ends SERVE)
//   maze_in                          registered wall bit returned to the solver
//   visit_count                      number of distinct visited cells
//   dump_valid/ready/row/data        visited-row stream back to the host
// ----------------------------------------------------------------------------
module maze_memory #(
   parameter int maze_width = 6
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        load_valid,
   output logic                        load_ready,
   input  logic [maze_width-1:0]       load_row,
   input  logic [(2**maze_width)-1:0]  load_data,
   input  logic                        load_last,
   input  logic [maze_width-1:0]       row,
   input  logic [maze_width-1:0]       col,
   input  logic                        maze_oe,
   input  logic                        maze_we,
   input  logic                        done,
   output logic                        maze_in,
   output logic [2*maze_width:0]       visit_count,
   output logic                        dump_valid,
   input  logic                        dump_ready,
   output logic [maze_width-1:0]       dump_row,
   output logic [(2**maze_width)-1:0]  dump_data
);

   localparam int N  = 2**maze_width;
   localparam int CW = 2*maze_width + 1;

   typedef enum logic [1:0] {
      LOAD  = 2'd0,
      SERVE = 2'd1,
      DUMP  = 2'd2
   } state_t;

   state_t                r_state;
   logic [N-1:0]          r_wall    [N];
   logic [N-1:0]          r_visited [N];
   logic [CW-1:0]         r_visitCount;
   logic [maze_width-1:0] r_ptr;
   logic                  r_mazeIn;
   logic                  r_loadReady;
   logic                  r_dumpValid;

   // Single state machine owning both bitmaps, the dump pointer and the
   // registered handshake outputs. Reset fills the wall map with walls so any
   // row the host never loads reads as blocked. Leaving DUMP clears only the
   // visited map; walls survive so a later load may update a subset of rows.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= LOAD;
         r_visitCount <= '0;
         r_ptr        <= '0;
         r_mazeIn     <= 1'b1;
         r_loadReady  <= 1'b1;
         r_dumpValid  <= 1'b0;
         for (int i = 0; i < N; i++) begin
            r_wall[i]    <= '1;
            r_visited[i] <= '0;
         end
      end else begin
         case (r_state)
            LOAD: begin
               r_mazeIn <= 1'b1;
               if (load_valid) begin
                  r_wall[load_row] <= load_data;
                  if (load_last) begin
                     r_state     <= SERVE;
                     r_loadReady <= 1'b0;
                  end
               end
            end
            SERVE: begin
               if (maze_oe) begin
                  r_mazeIn <= r_wall[row][col];
               end
               if (maze_we) begin
                  r_visited[row][col] <= 1'b1;
                  if (!r_visited[row][col]) begin
                     r_visitCount <= r_visitCount + CW'(1);
                  end
               end
               if (done) begin
                  r_state     <= DUMP;
                  r_dumpValid <= 1'b1;
               end
            end
            DUMP: begin
               r_mazeIn <= 1'b1;
               if (dump_ready) begin
                  if (r_ptr == {maze_width{1'b1}}) begin
                     r_state      <= LOAD;
                     r_ptr        <= '0;
                     r_visitCount <= '0;
                     r_dumpValid  <= 1'b0;
                     r_loadReady  <= 1'b1;
                     for (int i = 0; i < N; i++) begin
                        r_visited[i] <= '0;
                     end
                  end else begin
                     r_ptr <= r_ptr + maze_width'(1);
                  end
               end
            end
            default: begin
               r_state     <= LOAD;
               r_mazeIn    <= 1'b1;
               r_loadReady <= 1'b1;
               r_dumpValid <= 1'b0;
            end
         endcase
      end
   end

   // A read in the same cycle as done lands in r_mazeIn just as the state
   // leaves SERVE; gating on the state keeps maze_in at wall outside SERVE.
   assign maze_in     = (r_state == SERVE) ? r_mazeIn : 1'b1;
   assign load_ready  = r_loadReady;
   assign dump_valid  = r_dumpValid;
   assign visit_count = r_visitCount;
   assign dump_row    = r_ptr;
   assign dump_data   = r_visited[r_ptr];

endmodule
